// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding, defaults and parity helper for the UART receiver
package uart_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    localparam int OVERSAMPLE_DEF = 8;
    function automatic logic parity_bit(input logic [7:0] d, input logic odd);
        return (^d) ^ odd;
    endfunction
endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: synchronous FIFO with a valid/ready read side; a pop frees room for a same-cycle push
module uart_rx_fifo #(
    parameter int W = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] wdata,
    output logic         full,
    output logic         valid,
    input  logic         ready,
    output logic [W-1:0] rdata
);
    localparam int AW = $clog2(DEPTH);
    logic [AW:0] wp, rp;
    logic [W-1:0] mem [DEPTH];
    logic pop;
    assign pop = valid && ready;
    assign valid = wp != rp;
    assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign rdata = mem[rp[AW-1:0]];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp <= '0;
            rp <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push && (!full || pop)) begin
                mem[wp[AW-1:0]] <= wdata;
                wp <= wp + 1'b1;
            end
            if (pop) rp <= rp + 1'b1;
        end
    end
endmodule

// File: rtl/uart_rx_endpoint.sv
// uart_rx_endpoint: oversampling UART receiver with majority-voted sampling, RX FIFO and sticky error flags
module uart_rx_endpoint
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEF,
    parameter int DIV_W = 20,
    parameter int DATA_BITS = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             io_axiClk,
    input  logic             io_asyncResetn,
    input  logic [DIV_W-1:0] io_clkDivider,
    input  logic             io_parityEn,
    input  logic             io_parityOdd,
    input  logic             io_uart_rxd,
    output logic             io_rsp_valid,
    input  logic             io_rsp_ready,
    output logic [7:0]       io_rsp_payload,
    output logic             io_frameErr,
    output logic             io_parityErr,
    output logic             io_overrun,
    input  logic             io_clearErr,
    output logic             io_busy
);
    localparam int SCW = $clog2(OVERSAMPLE);
    localparam int BCW = $clog2(DATA_BITS);
    localparam logic [SCW-1:0] HALF = SCW'(OVERSAMPLE / 2 - 1);
    localparam logic [BCW-1:0] LAST = BCW'(DATA_BITS - 1);

    state_t state, state_n;
    logic [DIV_W-1:0] cnt, div_q;
    logic [1:0] sync;
    logic [2:0] taps;
    logic [SCW-1:0] sc;
    logic [BCW-1:0] bc;
    logic [DATA_BITS-1:0] data;
    logic tick, line, bit_s, mid, armed, par_en, par_odd, par_bad;
    logic push, full, pop, frame_set, par_set, ovr_set;

    assign tick = cnt == div_q;
    assign line = sync[1];
    assign bit_s = (taps[0] & taps[1]) | (taps[0] & taps[2]) | (taps[1] & taps[2]);
    assign mid = tick && sc == HALF;
    assign pop = io_rsp_valid && io_rsp_ready;

    // divider is latched at each wrap so a change never truncates a running period
    always_ff @(posedge io_axiClk or negedge io_asyncResetn) begin
        if (!io_asyncResetn) begin
            cnt <= '0;
            div_q <= '0;
            sync <= '1;
            taps <= '1;
        end else begin
            sync <= {sync[0], io_uart_rxd};
            cnt <= tick ? '0 : cnt + 1'b1;
            if (tick) begin
                div_q <= io_clkDivider;
                taps <= {taps[1:0], line};
            end
        end
    end

    always_ff @(posedge io_axiClk or negedge io_asyncResetn) begin
        if (!io_asyncResetn) state <= IDLE;
        else state <= state_n;
    end

    always_comb begin
        state_n = state;
        if (tick) begin
            case (state)
                IDLE:    if (armed && !line) state_n = START;
                START:   if (mid) state_n = bit_s ? IDLE : DATA;
                DATA:    if (mid && bc == LAST) state_n = par_en ? PARITY : STOP;
                PARITY:  if (mid) state_n = STOP;
                STOP:    if (mid) state_n = IDLE;
                default: state_n = IDLE;
            endcase
        end
    end

    always_comb begin
        push = state == STOP && mid && bit_s;
        frame_set = state == STOP && mid && !bit_s;
        par_set = push && par_bad;
        ovr_set = push && full && !pop;
        io_busy = state != IDLE;
    end

    // a low stop sample disarms until the line is seen high, so a break yields a single frame error
    always_ff @(posedge io_axiClk or negedge io_asyncResetn) begin
        if (!io_asyncResetn) begin
            sc <= '0;
            bc <= '0;
            data <= '0;
            armed <= 1'b0;
            par_en <= 1'b0;
            par_odd <= 1'b0;
            par_bad <= 1'b0;
        end else begin
            sc <= (state == IDLE) ? '0 : sc + SCW'(tick);
            if (state == IDLE && tick && line) armed <= 1'b1;
            else if (frame_set) armed <= 1'b0;
            if (state == START && mid) begin
                bc <= '0;
                par_en <= io_parityEn;
                par_odd <= io_parityOdd;
                par_bad <= 1'b0;
            end
            if (state == DATA && mid) begin
                data <= {bit_s, data[DATA_BITS-1:1]};
                bc <= bc + 1'b1;
            end
            if (state == PARITY && mid) par_bad <= bit_s != parity_bit(8'(data), par_odd);
        end
    end

    always_ff @(posedge io_axiClk or negedge io_asyncResetn) begin
        if (!io_asyncResetn) begin
            io_frameErr <= 1'b0;
            io_parityErr <= 1'b0;
            io_overrun <= 1'b0;
        end else if (io_clearErr) begin
            io_frameErr <= 1'b0;
            io_parityErr <= 1'b0;
            io_overrun <= 1'b0;
        end else begin
            io_frameErr <= io_frameErr | frame_set;
            io_parityErr <= io_parityErr | par_set;
            io_overrun <= io_overrun | ovr_set;
        end
    end

    uart_rx_fifo #(.W(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (io_axiClk),
        .rst_n (io_asyncResetn),
        .push  (push),
        .wdata (8'(data)),
        .full  (full),
        .valid (io_rsp_valid),
        .ready (io_rsp_ready),
        .rdata (io_rsp_payload)
    );
endmodule

// File: tb/tb_uart_rx_endpoint.sv
// tb_uart_rx_endpoint: directed frames at divider 3 / 8x oversampling, 32 clocks per bit
module tb_uart_rx_endpoint;
    import uart_pkg::*;
    logic clk = 1'b0;
    logic rst_n, rxd, ready_r, pop6, par_en, par_odd, clr;
    logic [19:0] div;
    logic valid, ready, frame_err, par_err, ovr, busy;
    logic [7:0] payload;
    int n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;
    // pop6 raises ready exactly on the stop-sample cycle to exercise push+pop while full
    assign ready = ready_r | (pop6 && dut.state == STOP && dut.mid);

    uart_rx_endpoint dut (
        .io_axiClk      (clk),
        .io_asyncResetn (rst_n),
        .io_clkDivider  (div),
        .io_parityEn    (par_en),
        .io_parityOdd   (par_odd),
        .io_uart_rxd    (rxd),
        .io_rsp_valid   (valid),
        .io_rsp_ready   (ready),
        .io_rsp_payload (payload),
        .io_frameErr    (frame_err),
        .io_parityErr   (par_err),
        .io_overrun     (ovr),
        .io_clearErr    (clr),
        .io_busy        (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_bit(input logic v);
        rxd = v;
        step(32);
    endtask

    task automatic send_body(input logic [7:0] d, input logic hp, input logic pb);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (hp) drive_bit(pb);
    endtask

    task automatic pulse_clear();
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        step(1);
    endtask

    task automatic finish_frame(input logic stop, input logic chk_rise, input logic [7:0] exp);
        logic pv;
        logic done;
        rxd = stop;
        pv = valid;
        done = 1'b0;
        for (int i = 0; i < 64 && !done; i++) begin
            pv = valid;
            step(1);
            if (!busy) done = 1'b1;
        end
        chk("busy_fall", 32'(done), 1);
        if (chk_rise) begin
            chk("valid_before_stop", 32'(pv), 0);
            chk("valid_rise", 32'(valid), 1);
            chk("payload", 32'(payload), 32'(exp));
        end
        rxd = 1'b1;
        step(32);
    endtask

    initial begin
        logic saw;
        logic [7:0] exp_q [4];
        rst_n = 1'b0; rxd = 1'b1; ready_r = 1'b1; pop6 = 1'b0;
        par_en = 1'b0; par_odd = 1'b0; clr = 1'b0; div = 20'd3;
        step(4);
        chk("rst_valid", 32'(valid), 0);
        chk("rst_payload", 32'(payload), 0);
        chk("rst_frame", 32'(frame_err), 0);
        chk("rst_parity", 32'(par_err), 0);
        chk("rst_overrun", 32'(ovr), 0);
        chk("rst_busy", 32'(busy), 0);
        rst_n = 1'b1;
        step(40);

        send_body(8'h55, 1'b0, 1'b0);
        finish_frame(1'b1, 1'b1, 8'h55);
        send_body(8'hA3, 1'b0, 1'b0);
        finish_frame(1'b1, 1'b1, 8'hA3);
        chk("clean_frame", 32'(frame_err), 0);
        chk("clean_parity", 32'(par_err), 0);
        chk("clean_overrun", 32'(ovr), 0);

        rxd = 1'b0;
        step(4);
        rxd = 1'b1;
        saw = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step(1);
            if (busy) saw = 1'b1;
        end
        step(40);
        chk("glitch_busy_pulse", 32'(saw), 1);
        chk("glitch_idle", 32'(busy), 0);
        chk("glitch_no_valid", 32'(valid), 0);

        par_en = 1'b1;
        send_body(8'h07, 1'b1, 1'b1);
        finish_frame(1'b1, 1'b1, 8'h07);
        chk("parity_good", 32'(par_err), 0);
        send_body(8'h07, 1'b1, 1'b0);
        finish_frame(1'b1, 1'b1, 8'h07);
        chk("parity_bad", 32'(par_err), 1);
        pulse_clear();
        chk("parity_clear", 32'(par_err), 0);
        par_en = 1'b0;

        send_body(8'h3C, 1'b0, 1'b0);
        finish_frame(1'b0, 1'b0, 8'h00);
        chk("frame_no_push", 32'(valid), 0);
        chk("frame_err", 32'(frame_err), 1);
        pulse_clear();
        chk("frame_clear", 32'(frame_err), 0);

        rxd = 1'b0;
        step(400);
        chk("break_err", 32'(frame_err), 1);
        pulse_clear();
        step(560);
        chk("break_single_err", 32'(frame_err), 0);
        chk("break_waits", 32'(busy), 0);
        chk("break_no_valid", 32'(valid), 0);
        rxd = 1'b1;
        step(64);
        send_body(8'h5A, 1'b0, 1'b0);
        finish_frame(1'b1, 1'b1, 8'h5A);
        chk("rearm_frame", 32'(frame_err), 0);

        ready_r = 1'b0;
        for (int b = 1; b <= 5; b++) begin
            send_body(8'(b), 1'b0, 1'b0);
            finish_frame(1'b1, b == 1, 8'(b));
        end
        chk("overrun_set", 32'(ovr), 1);
        chk("full_valid", 32'(valid), 1);
        chk("full_head", 32'(payload), 32'h01);
        pulse_clear();
        chk("overrun_clear", 32'(ovr), 0);
        pop6 = 1'b1;
        send_body(8'h06, 1'b0, 1'b0);
        finish_frame(1'b1, 1'b0, 8'h00);
        pop6 = 1'b0;
        chk("push_pop_full", 32'(ovr), 0);
        exp_q = '{8'h02, 8'h03, 8'h04, 8'h06};
        ready_r = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_valid", 32'(valid), 1);
            chk("drain_payload", 32'(payload), 32'(exp_q[i]));
            step(1);
        end
        chk("drain_empty", 32'(valid), 0);

        ready_r = 1'b0;
        send_body(8'h99, 1'b0, 1'b0);
        finish_frame(1'b1, 1'b1, 8'h99);
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(1'b1);
        chk("mid_frame_busy", 32'(busy), 1);
        rst_n = 1'b0;
        step(1);
        chk("mrst_valid", 32'(valid), 0);
        chk("mrst_busy", 32'(busy), 0);
        chk("mrst_payload", 32'(payload), 0);
        chk("mrst_flags", 32'({frame_err, par_err, ovr}), 0);
        rst_n = 1'b1;
        rxd = 1'b1;
        ready_r = 1'b1;
        step(64);
        send_body(8'h12, 1'b0, 1'b0);
        finish_frame(1'b1, 1'b1, 8'h12);
        chk("post_rst_flags", 32'({frame_err, par_err, ovr}), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_rx_endpoint.md
Name: uart_rx_endpoint

Overview:
- Synthesizable UART receiver that terminates the SoC's io_uart_txd line.
- Used in the SoC-level bench as a console decoder, and reusable as the SoC's own RX peripheral core.
- Oversamples the serial line, decodes 8N1 (optionally parity) frames, and buffers bytes in a small FIFO.
- Presents buffered bytes on a valid/ready stream; reports framing, parity and overrun errors as sticky flags.

Parameters:
- OVERSAMPLE, 8, samples per bit period (power of 2, 4..16).
- DIV_W, 20, width of the clock-divider input.
- DATA_BITS, 8, data bits per frame (5..8).
- FIFO_DEPTH, 4, RX FIFO entries (power of 2, ≥2).

Ports:
- io_axiClk  in  1  single clock.
- io_asyncResetn  in  1  asynchronous active-low reset.
- io_clkDivider  in  DIV_W  io_axiClk cycles per oversample tick, minus 1.
- io_parityEn  in  1  1 = parity bit expected after data.
- io_parityOdd  in  1  1 = odd parity, 0 = even; ignored when io_parityEn=0.
- io_uart_rxd  in  1  serial line, idle high, asynchronous to io_axiClk.
- io_rsp_valid  out  1  FIFO head valid.
- io_rsp_ready  in  1  consumer accepts head.
- io_rsp_payload  out  8  received byte, zero-extended when DATA_BITS<8.
- io_frameErr  out  1  sticky: stop bit sampled low.
- io_parityErr  out  1  sticky: parity mismatch.
- io_overrun  out  1  sticky: frame completed while FIFO full.
- io_clearErr  in  1  synchronous clear of all sticky flags.
- io_busy  out  1  state != IDLE.

Behaviour:
- Reset (async assert, sync release via two-flop deassert in parent): all outputs 0; FIFO empty; state IDLE; synchronizer flops = 1.
- Input path: io_uart_rxd passes a 2-flop synchronizer, then a 3-tap shift register updated on each tick. Sampled bit = majority of the 3 taps.
- Tick generator: counter counts 0..io_clkDivider; tick pulses for one cycle at terminal count, then the counter wraps to 0. io_clkDivider=0 gives a tick every cycle. A divider change takes effect at the next wrap.
- Sample counter sc counts 0..OVERSAMPLE-1 on ticks.
- State machine (advances only on ticks):
  - IDLE: on synchronized line low, go to START with sc=0.
  - START: at sc=OVERSAMPLE/2-1, if majority is low, go to DATA; if high (glitch), return to IDLE and record nothing.
  - DATA: samples at each subsequent bit centre (sc wraps OVERSAMPLE-1→0, sample at OVERSAMPLE/2-1). LSB first, shifted into the data register. After DATA_BITS samples, go to PARITY if io_parityEn, else STOP.
  - PARITY: one sample; compare against XOR of the data bits (inverted when io_parityOdd).
  - STOP: one sample, then return to IDLE. The line is not required to return high earlier.
- Frame completion (cycle of the STOP sample):
  - Stop bit low → set io_frameErr and drop the byte.
  - Parity mismatch → set io_parityErr but still push the byte.
  - FIFO full → set io_overrun and drop the new byte; FIFO contents are unchanged.
- Latency: io_rsp_valid rises the cycle after the STOP sample (registered FIFO).
- FIFO:
  - Push and pop in the same cycle are legal at any occupancy, including full.
  - A pop occurs when io_rsp_valid && io_rsp_ready.
  - io_rsp_payload is stable while valid && !ready.
  - Pointers are log2(FIFO_DEPTH)+1 bits; full/empty are derived from the MSB compare.
- Sticky flags: io_clearErr has priority over a set in the same cycle (clear wins); a new error on the next cycle sets again.
- io_parityEn/io_parityOdd are sampled at the START→DATA transition and held for the frame.
- A break (line held low) produces one frame error, then waits in IDLE until the line goes high before re-arming. This requires an IDLE-arm bit set by a high sample.

Decomposition:
- Package uart_pkg: state enum (IDLE, START, DATA, PARITY, STOP), OVERSAMPLE default, parity helper function.
- One sub-module: uart_rx_fifo (parameterized synchronous FIFO with valid/ready output). Tick generator and FSM stay in the top module.

Test Plan:
- Divider=3, OVERSAMPLE=8, 8N1, send 0x55 then 0xA3, ready=1 → payloads 0x55, 0xA3 in order; each valid 1 cycle after its stop sample; no flags set.
- 1-tick low glitch on an idle line → no valid, state back in IDLE, io_busy pulses then clears.
- Parity even enabled, send 0x07 with parity bit 0 (wrong) → byte 0x07 delivered, io_parityErr=1; io_clearErr → 0.
- Stop bit driven low on 0x3C → nothing pushed, io_frameErr=1. Line held low 3 frames → still one error, no bytes; re-arms after the line goes high.
- ready=0, send 5 bytes 0x01..0x05 with FIFO_DEPTH=4 → 0x01..0x04 retained, io_overrun=1. Raise ready with a simultaneous 6th frame finishing → no loss of 0x06.
- Assert reset mid-DATA of 0xFF → outputs 0, FIFO empty. After release, the next clean 0x12 is received correctly.
